compare_result_filter: RTL and testbench
========================================

Name: compare_result_filter

Overview:
- Sits directly downstream of the 4-bit magnitude comparator and consumes its three outputs (A_gt_B, A_lt_B, A_eq_B) once per sampled cycle.
- Debounces the comparison into a filtered relation state, which changes only after STABLE_CNT consecutive identical valid samples.
- Emits a one-cycle change pulse and keeps saturating per-class event counters for monitoring.
- Flags and counts malformed inputs, i.e. inputs where the three flags are not exactly one-hot.

Parameters:
- STABLE_CNT, 3: consecutive identical valid samples required to change the filtered state; legal range 1..15.
- CNT_W, 8: width of each event counter.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of state and counters.
- in_valid  in  1  comparator outputs are sampled this cycle.
- A_gt_B  in  1  comparator greater-than flag.
- A_lt_B  in  1  comparator less-than flag.
- A_eq_B  in  1  comparator equal flag.
- rel_state  out  2  filtered relation: 00 UNKNOWN, 01 LT, 10 EQ, 11 GT.
- change_pulse  out  1  high for one cycle when rel_state changes.
- err_pulse  out  1  high for one cycle after a non-one-hot valid sample.
- gt_count  out  CNT_W  count of valid GT samples.
- lt_count  out  CNT_W  count of valid LT samples.
- eq_count  out  CNT_W  count of valid EQ samples.
- err_count  out  CNT_W  count of malformed samples.

Behaviour:
- Reset (reset_n=0, asynchronous): every output is 0, rel_state is UNKNOWN, candidate is UNKNOWN, run=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Sample decode, applied when in_valid=1:
  - exactly one of {gt, lt, eq} high: the sample is that class;
  - otherwise (000, 011, 101, 110, 111): the sample is ERR.
- Candidate/run tracking on a class sample:
  - class == candidate: run <= min(run+1, STABLE_CNT);
  - class != candidate: candidate <= class, run <= 1.
- State update, in the same edge:
  - if the new run == STABLE_CNT and candidate-after-update != rel_state, then rel_state <= candidate and change_pulse <= 1.
  - Latency: rel_state updates on the edge that samples the STABLE_CNT-th consecutive identical sample.
  - STABLE_CNT=1 means rel_state follows every valid sample at one-cycle latency.
- ERR sample:
  - err_pulse <= 1, err_count increments;
  - candidate <= UNKNOWN, run <= 0 (breaks the streak);
  - rel_state unchanged.
- in_valid=0: state, candidate, run and counters hold. Gaps do not break a streak. Pulses deassert.
- change_pulse and err_pulse are high for exactly one cycle per triggering sample; otherwise 0.
- Counters:
  - the class counter increments on every valid class sample, regardless of filtering;
  - all counters saturate at 2^CNT_W-1 and never wrap.
- clear=1:
  - next edge zeroes all counters and pulses, sets rel_state and candidate to UNKNOWN, run=0;
  - clear has priority over a simultaneous in_valid sample, which is discarded.
- Once left, UNKNOWN is re-entered only via reset or clear. An ERR leaves rel_state at its last value.
- reset_n asserted mid-streak: immediate return to the reset values. The streak restarts from zero after release.

Decomposition:
- Shared package cmp_pkg holds:
  - the rel_state encoding constants REL_UNKNOWN=2'b00, REL_LT=2'b01, REL_EQ=2'b10, REL_GT=2'b11;
  - the class decode function.
- One natural sub-module: sat_counter, with parameter W and ports clock, reset_n, clr, inc, count. It is instantiated four times, once per event counter.
- The filter state machine stays in the top module.

Test Plan:
- Reset then idle: reset_n low mid-cycle -> all outputs 0 immediately; with in_valid=0 for 10 cycles, outputs stay 0.
- STABLE_CNT=3, GT,GT,GT: rel_state=11 and change_pulse=1 on the 3rd sample edge; gt_count=3.
- Streak held across a gap: GT, GT, gap of 2 cycles (in_valid=0), GT -> rel_state=11 on the 3rd sample; run not broken.
- Streak broken by a different class: GT,GT,LT,GT,GT,GT -> no change until the 6th sample; gt_count=5, lt_count=1.
- Malformed input: A_gt_B=A_eq_B=1 mid-streak -> err_pulse=1, err_count=1, rel_state held; the streak needs 3 fresh samples.
- Saturation and clear, CNT_W=4: 20 EQ samples -> eq_count=15. Then clear together with in_valid EQ -> all counters 0, rel_state=00, no change_pulse.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator result filter.
// Holds the rel_state encoding, the decoded-sample payload and the
// function that classifies the comparator's three flags.
package cmp_pkg;

    localparam logic [1:0] REL_UNKNOWN = 2'b00;
    localparam logic [1:0] REL_LT      = 2'b01;
    localparam logic [1:0] REL_EQ      = 2'b10;
    localparam logic [1:0] REL_GT      = 2'b11;

    // Decoded sample: err set when the flags are not exactly one-hot.
    typedef struct packed {
        logic       err;
        logic [1:0] rel;
    } cls_t;

    function automatic cls_t cmp_decode(input logic gt, input logic lt, input logic eq);
        cls_t r;
        r.err = 1'b0;
        r.rel = REL_UNKNOWN;
        case ({gt, lt, eq})
            3'b100:  r.rel = REL_GT;
            3'b010:  r.rel = REL_LT;
            3'b001:  r.rel = REL_EQ;
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
// Ports: clock, reset_n (async active-low), clr (sync clear),
//        inc (count enable), count (registered value).
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/compare_result_filter.sv
// Debounces the 4-bit comparator's gt/lt/eq flags into a filtered relation,
// pulses on relation changes and on malformed samples, and keeps
// saturating per-class event counters.
// Ports: clock, reset_n (async active-low), clear (sync clear),
//        in_valid + A_gt_B/A_lt_B/A_eq_B (sample), rel_state (filtered
//        relation), change_pulse, err_pulse, gt/lt/eq/err_count.
module compare_result_filter
    import cmp_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             A_gt_B,
    input  logic             A_lt_B,
    input  logic             A_eq_B,
    output logic [1:0]       rel_state,
    output logic             change_pulse,
    output logic             err_pulse,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] lt_count,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] err_count
);

    // Run length never exceeds STABLE_CNT (max 15).
    localparam int unsigned RUN_W = 4;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CNT);

    logic [1:0]       r_rel;
    logic [1:0]       r_cand;
    logic [RUN_W-1:0] r_run;
    logic             r_chg;
    logic             r_err;

    logic [1:0]       w_rel_n;
    logic [1:0]       w_cand_n;
    logic [RUN_W-1:0] w_run_n;
    logic             w_chg_n;
    logic             w_err_n;

    cls_t w_dec;
    logic w_take;

    assign w_dec  = cmp_decode(A_gt_B, A_lt_B, A_eq_B);
    // clear wins over a simultaneous sample, which is dropped.
    assign w_take = in_valid && !clear;

    // Next-state for relation, candidate streak and pulses.
    always_comb begin
        w_rel_n  = r_rel;
        w_cand_n = r_cand;
        w_run_n  = r_run;
        w_chg_n  = 1'b0;
        w_err_n  = 1'b0;
        if (clear) begin
            w_rel_n  = REL_UNKNOWN;
            w_cand_n = REL_UNKNOWN;
            w_run_n  = '0;
        end else if (in_valid) begin
            if (w_dec.err) begin
                // Malformed sample breaks the streak but keeps the relation.
                w_err_n  = 1'b1;
                w_cand_n = REL_UNKNOWN;
                w_run_n  = '0;
            end else begin
                if (w_dec.rel == r_cand) begin
                    w_run_n = (r_run >= RUN_MAX) ? RUN_MAX : r_run + RUN_W'(1);
                end else begin
                    w_cand_n = w_dec.rel;
                    w_run_n  = RUN_W'(1);
                end
                if ((w_run_n == RUN_MAX) && (w_cand_n != r_rel)) begin
                    w_rel_n = w_cand_n;
                    w_chg_n = 1'b1;
                end
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rel  <= REL_UNKNOWN;
            r_cand <= REL_UNKNOWN;
            r_run  <= '0;
            r_chg  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_rel  <= w_rel_n;
            r_cand <= w_cand_n;
            r_run  <= w_run_n;
            r_chg  <= w_chg_n;
            r_err  <= w_err_n;
        end
    end

    assign rel_state    = r_rel;
    assign change_pulse = r_chg;
    assign err_pulse    = r_err;

    logic w_inc_gt;
    logic w_inc_lt;
    logic w_inc_eq;
    logic w_inc_err;

    assign w_inc_gt  = w_take && !w_dec.err && (w_dec.rel == REL_GT);
    assign w_inc_lt  = w_take && !w_dec.err && (w_dec.rel == REL_LT);
    assign w_inc_eq  = w_take && !w_dec.err && (w_dec.rel == REL_EQ);
    assign w_inc_err = w_take && w_dec.err;

    sat_counter #(.W(CNT_W)) u_gt_cnt (
        .clock(clock), .reset_n(reset_n), .clr(clear), .inc(w_inc_gt), .count(gt_count)
    );
    sat_counter #(.W(CNT_W)) u_lt_cnt (
        .clock(clock), .reset_n(reset_n), .clr(clear), .inc(w_inc_lt), .count(lt_count)
    );
    sat_counter #(.W(CNT_W)) u_eq_cnt (
        .clock(clock), .reset_n(reset_n), .clr(clear), .inc(w_inc_eq), .count(eq_count)
    );
    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clock(clock), .reset_n(reset_n), .clr(clear), .inc(w_inc_err), .count(err_count)
    );

endmodule

// File: tb/tb_compare_result_filter.sv
// Randomized and directed bench for compare_result_filter against a
// sample-history reference model.
module tb_compare_result_filter;

    localparam int S    = 3;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    localparam logic [2:0] F_GT = 3'b100;
    localparam logic [2:0] F_LT = 3'b010;
    localparam logic [2:0] F_EQ = 3'b001;

    logic          clock;
    logic          reset_n;
    logic          clear;
    logic          in_valid;
    logic          A_gt_B;
    logic          A_lt_B;
    logic          A_eq_B;
    logic [1:0]    rel_state;
    logic          change_pulse;
    logic          err_pulse;
    logic [CW-1:0] gt_count;
    logic [CW-1:0] lt_count;
    logic [CW-1:0] eq_count;
    logic [CW-1:0] err_count;

    compare_result_filter #(.STABLE_CNT(S), .CNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .A_gt_B(A_gt_B), .A_lt_B(A_lt_B), .A_eq_B(A_eq_B),
        .rel_state(rel_state), .change_pulse(change_pulse), .err_pulse(err_pulse),
        .gt_count(gt_count), .lt_count(lt_count), .eq_count(eq_count), .err_count(err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: history of class samples since the last break.
    int m_rel, m_chg, m_errp, m_gt, m_lt, m_eq, m_err;
    int m_hist[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    task automatic model_reset();
        m_rel = 0; m_chg = 0; m_errp = 0;
        m_gt = 0; m_lt = 0; m_eq = 0; m_err = 0;
        m_hist.delete();
    endtask

    task automatic model_step(input logic v, input logic [2:0] f, input logic c);
        int cls;
        bit same;
        m_chg  = 0;
        m_errp = 0;
        if (c) begin
            model_reset();
        end else if (v) begin
            if (f != F_GT && f != F_LT && f != F_EQ) begin
                m_errp = 1;
                m_err  = sat_inc(m_err);
                m_hist.delete();
            end else begin
                cls = (f == F_GT) ? 3 : (f == F_LT) ? 1 : 2;
                if (cls == 3) m_gt = sat_inc(m_gt);
                if (cls == 1) m_lt = sat_inc(m_lt);
                if (cls == 2) m_eq = sat_inc(m_eq);
                m_hist.push_back(cls);
                if (m_hist.size() > S) void'(m_hist.pop_front());
                same = (m_hist.size() == S);
                foreach (m_hist[i]) if (m_hist[i] != cls) same = 0;
                if (same && cls != m_rel) begin
                    m_rel = cls;
                    m_chg = 1;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".rel"}, 32'(rel_state), 32'(m_rel));
        chk({tag, ".chg"}, 32'(change_pulse), 32'(m_chg));
        chk({tag, ".errp"}, 32'(err_pulse), 32'(m_errp));
        chk({tag, ".gt"}, 32'(gt_count), 32'(m_gt));
        chk({tag, ".lt"}, 32'(lt_count), 32'(m_lt));
        chk({tag, ".eq"}, 32'(eq_count), 32'(m_eq));
        chk({tag, ".err"}, 32'(err_count), 32'(m_err));
    endtask

    // Drive one cycle, sample #1 after the edge, check against the model.
    task automatic step(input string tag, input logic v, input logic [2:0] f, input logic c);
        in_valid = v;
        {A_gt_B, A_lt_B, A_eq_B} = f;
        clear = c;
        @(posedge clock);
        model_step(v, f, c);
        #1;
        compare_all(tag);
    endtask

    initial begin
        logic [2:0] f;
        logic [2:0] last_f;
        logic       v;
        logic       c;

        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        A_gt_B = 1'b0; A_lt_B = 1'b0; A_eq_B = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        compare_all("rst0");
        #3 reset_n = 1'b1;

        // GT x3: relation flips on the third sample.
        step("gt1", 1, F_GT, 0);
        step("gt2", 1, F_GT, 0);
        chk("gt2_rel_const", 32'(rel_state), 32'd0);
        step("gt3", 1, F_GT, 0);
        chk("gt3_rel_const", 32'(rel_state), 32'd3);
        chk("gt3_chg_const", 32'(change_pulse), 32'd1);
        chk("gt3_cnt_const", 32'(gt_count), 32'd3);
        step("gt4", 1, F_GT, 0);
        chk("gt4_chg_const", 32'(change_pulse), 32'd0);

        // Asynchronous reset mid-cycle, then idle.
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        compare_all("arst");
        chk("arst_rel_const", 32'(rel_state), 32'd0);
        chk("arst_gt_const", 32'(gt_count), 32'd0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 10; i++) step("idle", 0, F_GT, 0);
        chk("idle_rel_const", 32'(rel_state), 32'd0);

        // Gap does not break a streak.
        step("gap1", 1, F_GT, 0);
        step("gap2", 1, F_GT, 0);
        step("gap3", 0, 3'b000, 0);
        step("gap4", 0, F_LT, 0);
        step("gap5", 1, F_GT, 0);
        chk("gap_rel_const", 32'(rel_state), 32'd3);

        // Streak broken by a different class.
        step("clr", 0, 3'b000, 1);
        step("brk1", 1, F_GT, 0);
        step("brk2", 1, F_GT, 0);
        step("brk3", 1, F_LT, 0);
        step("brk4", 1, F_GT, 0);
        step("brk5", 1, F_GT, 0);
        chk("brk5_rel_const", 32'(rel_state), 32'd0);
        step("brk6", 1, F_GT, 0);
        chk("brk6_rel_const", 32'(rel_state), 32'd3);
        chk("brk6_gt_const", 32'(gt_count), 32'd5);
        chk("brk6_lt_const", 32'(lt_count), 32'd1);

        // Malformed sample mid-streak.
        step("mal1", 1, F_LT, 0);
        step("mal2", 1, F_LT, 0);
        step("mal3", 1, 3'b101, 0);
        chk("mal_errp_const", 32'(err_pulse), 32'd1);
        chk("mal_errc_const", 32'(err_count), 32'd1);
        chk("mal_rel_const", 32'(rel_state), 32'd3);
        step("mal4", 1, F_LT, 0);
        step("mal5", 1, F_LT, 0);
        chk("mal5_rel_const", 32'(rel_state), 32'd3);
        step("mal6", 1, F_LT, 0);
        chk("mal6_rel_const", 32'(rel_state), 32'd1);

        // Saturation then clear with a simultaneous sample.
        for (int i = 0; i < 20; i++) step("sat", 1, F_EQ, 0);
        chk("sat_eq_const", 32'(eq_count), 32'(MAXC));
        step("clrv", 1, F_EQ, 1);
        chk("clrv_eq_const", 32'(eq_count), 32'd0);
        chk("clrv_rel_const", 32'(rel_state), 32'd0);
        chk("clrv_chg_const", 32'(change_pulse), 32'd0);

        // Randomized run with streak-friendly class bias.
        last_f = F_GT;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) == 0) begin
                f = 3'($urandom_range(0, 7));
            end else if ($urandom_range(0, 9) < 7) begin
                f = last_f;
            end else begin
                case ($urandom_range(0, 2))
                    0:       f = F_GT;
                    1:       f = F_LT;
                    default: f = F_EQ;
                endcase
            end
            if (f == F_GT || f == F_LT || f == F_EQ) last_f = f;
            step("rnd", v, f, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
